// File: rtl/pipe_add_pkg.sv
// Shared types and elaboration helpers for the pipelined adder/subtractor.
package pipe_add_pkg;

    typedef struct packed {
        logic carry;
        logic ovf;
        logic zero;
    } flags_t;

    function automatic bit params_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= 8) && (width > 0) && (width % stages == 0);
    endfunction

    function automatic int chunk_width(input int width, input int stages);
        return (stages > 0) ? width / stages : width;
    endfunction

endpackage

// File: rtl/pipe_add_stage.sv
// One pipeline stage: adds chunk K of the operand buses with the incoming carry
// and forwards the partially built result plus the operands to the next stage.
module pipe_add_stage
    import pipe_add_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CW    = 16,
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  logic             vld_in,
    input  logic             cin,
    input  logic [WIDTH-1:0] res_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             vld_q,
    output logic             cout_q,
    output logic [WIDTH-1:0] res_q,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q
);

    logic [CW:0]      csum;
    logic [WIDTH-1:0] res_d;

    assign csum = {1'b0, a_in[K*CW +: CW]} + {1'b0, b_in[K*CW +: CW]} + {{CW{1'b0}}, cin};

    always_comb begin
        res_d              = res_in;
        res_d[K*CW +: CW]  = csum[CW-1:0];
    end

    // Bubbles only move the valid bit; data holds so idle outputs stay quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            cout_q <= 1'b0;
            res_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
        end else if (adv) begin
            vld_q <= vld_in;
            if (vld_in) begin
                cout_q <= csum[CW];
                res_q  <= res_d;
                a_q    <= a_in;
                b_q    <= b_in;
            end
        end
    end

endmodule

// File: rtl/pipe_add.sv
// Pipelined WIDTH-bit adder/subtractor split into STAGES carry-chained chunks.
// Define PIPE_ADD_FLAGS_EN to add the carry/ovf/zero outputs.
module pipe_add
    import pipe_add_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef PIPE_ADD_FLAGS_EN
    output logic             carry,
    output logic             ovf,
    output logic             zero,
`endif
    output logic [WIDTH-1:0] sum
);

    localparam int CW = chunk_width(WIDTH, STAGES);

    if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
        $error("pipe_add: STAGES must be 1..8 and divide WIDTH");
    end

    logic                         adv;
    logic [STAGES:0]              vld_pipe;
    logic [STAGES:0]              cy;
    logic [STAGES:0][WIDTH-1:0]   res_pipe;
    logic [STAGES:0][WIDTH-1:0]   a_pipe;
    logic [STAGES:0][WIDTH-1:0]   b_pipe;

    // Whole pipe moves as one; a stalled consumer freezes every stage.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Subtract is A + ~B with the +1 injected as stage 0 carry-in.
    assign vld_pipe[0] = in_valid;
    assign cy[0]       = sub;
    assign res_pipe[0] = '0;
    assign a_pipe[0]   = a;
    assign b_pipe[0]   = sub ? ~b : b;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipe_add_stage #(
            .WIDTH (WIDTH),
            .CW    (CW),
            .K     (k)
        ) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .adv    (adv),
            .vld_in (vld_pipe[k]),
            .cin    (cy[k]),
            .res_in (res_pipe[k]),
            .a_in   (a_pipe[k]),
            .b_in   (b_pipe[k]),
            .vld_q  (vld_pipe[k+1]),
            .cout_q (cy[k+1]),
            .res_q  (res_pipe[k+1]),
            .a_q    (a_pipe[k+1]),
            .b_q    (b_pipe[k+1])
        );
    end

    assign out_valid = vld_pipe[STAGES];
    assign sum       = res_pipe[STAGES];

`ifdef PIPE_ADD_FLAGS_EN
    flags_t flg;

    // All flag terms come from last-stage registers; zero is masked when idle.
    assign flg.carry = cy[STAGES];
    assign flg.ovf   = (a_pipe[STAGES][WIDTH-1] == b_pipe[STAGES][WIDTH-1]) &&
                       (res_pipe[STAGES][WIDTH-1] != a_pipe[STAGES][WIDTH-1]);
    assign flg.zero  = vld_pipe[STAGES] && (res_pipe[STAGES] == '0);

    assign carry = flg.carry;
    assign ovf   = flg.ovf;
    assign zero  = flg.zero;
`endif

    // Operand copies and final carry feed only the optional flag logic.
    logic unused_tail;
    assign unused_tail = ^{a_pipe[STAGES], b_pipe[STAGES], cy[STAGES]};

endmodule

// File: tb/tb_pipe_add.sv
// Scoreboard bench for pipe_add: directed vectors, back-pressure, reset, and a 64-bit sweep.
module tb_pipe_add;

    localparam int W   = 32;
    localparam int ST  = 2;
    localparam int SWW = 64;

    typedef struct {
        logic [63:0] s;
        logic        c;
        logic        o;
        logic        z;
        int          acc;
        int          stl;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, in_ready, sub, out_valid, out_ready;
    logic [W-1:0] a, b, sum;
`ifdef PIPE_ADD_FLAGS_EN
    logic carry, ovf, zero;
    logic [2:0] sw_c, sw_o, sw_z;
`endif
    logic [2:0] sw_iv, sw_ir, sw_sub, sw_ov, sw_or;
    logic [2:0][SWW-1:0] sw_a, sw_b, sw_sum;

    int   nchk = 0;
    int   nfail = 0;
    int   edges = 0;
    int   stalls = 0;
    bit   head_seen;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    pipe_add #(.WIDTH(W), .STAGES(ST)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
`ifdef PIPE_ADD_FLAGS_EN
        .carry(carry), .ovf(ovf), .zero(zero),
`endif
        .sum(sum)
    );

    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int SST = (g == 0) ? 1 : (g == 1) ? 4 : 8;
        pipe_add #(.WIDTH(SWW), .STAGES(SST)) u_dut (
            .clk(clk), .rst_n(rst_n), .in_valid(sw_iv[g]), .in_ready(sw_ir[g]),
            .a(sw_a[g]), .b(sw_b[g]), .sub(sw_sub[g]), .out_valid(sw_ov[g]),
            .out_ready(sw_or[g]),
`ifdef PIPE_ADD_FLAGS_EN
            .carry(sw_c[g]), .ovf(sw_o[g]), .zero(sw_z[g]),
`endif
            .sum(sw_sum[g])
        );
    end

    function automatic exp_t model(input int w, input logic [63:0] x, input logic [63:0] y,
                                   input logic s);
        logic [63:0] mask, xx, yy;
        logic [64:0] r;
        exp_t e;
        mask  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        xx    = x & mask;
        yy    = s ? (~y & mask) : (y & mask);
        r     = {1'b0, xx} + {1'b0, yy} + {64'd0, s};
        e.s   = r[63:0] & mask;
        e.c   = r[w];
        e.o   = (xx[w-1] == yy[w-1]) && (e.s[w-1] != xx[w-1]);
        e.z   = (e.s == 64'd0);
        e.acc = 0;
        e.stl = 0;
        return e;
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        nchk++;
        if (out_valid !== 1'b0 || sum !== '0) begin
            nfail++;
            $display("FAIL rst_hold: out_valid=%b sum=%h, required 0/0", out_valid, sum);
        end
        nchk++;
        if (sw_ov !== 3'b000 || sw_sum !== '0) begin
            nfail++;
            $display("FAIL rst_hold_sweep: out_valid=%b, required 000", sw_ov);
        end
`ifdef PIPE_ADD_FLAGS_EN
        nchk++;
        if ({carry, ovf, zero} !== 3'b000) begin
            nfail++;
            $display("FAIL rst_flags: got %b required 000", {carry, ovf, zero});
        end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        nchk++;
        if (out_valid !== 1'b0 || sum !== '0 || in_ready !== 1'b1) begin
            nfail++;
            $display("FAIL rst_release: out_valid=%b sum=%h in_ready=%b, required 0/0/1",
                     out_valid, sum, in_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] va [6];
        logic [31:0] vb [6];
        logic        vs [6];
        exp_t e;
        int   i, cyc;
        va = '{32'h0000FFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd7, 32'h80000000};
        vb = '{32'd1, 32'd1, 32'd1, 32'd7, 32'd7, 32'd1};
        vs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        i = 0; cyc = 0; q.delete();
        out_ready = 1'b1;
        while ((i < 6 || q.size() > 0) && cyc < 50) begin
            in_valid = (i < 6);
            if (i < 6) begin a = va[i]; b = vb[i]; sub = vs[i]; end
            #1;
            if (out_valid) begin
                if (q.size() == 0) begin
                    nchk++; nfail++;
                    $display("FAIL dir_spurious: out_valid=1 with nothing expected");
                end else begin
                    e = q.pop_front();
                    nchk++;
                    if (edges !== e.acc + ST) begin
                        nfail++;
                        $display("FAIL dir_latency: got %0d cycles required %0d", edges - e.acc, ST);
                    end
                    nchk++;
                    if (sum !== e.s[W-1:0]) begin
                        nfail++;
                        $display("FAIL dir_sum: got %h required %h", sum, e.s[W-1:0]);
                    end
`ifdef PIPE_ADD_FLAGS_EN
                    nchk++;
                    if ({carry, ovf, zero} !== {e.c, e.o, e.z}) begin
                        nfail++;
                        $display("FAIL dir_flags: got c/o/z=%b required %b",
                                 {carry, ovf, zero}, {e.c, e.o, e.z});
                    end
`endif
                end
            end
            if (in_valid && in_ready) begin
                e = model(W, {32'd0, a}, {32'd0, b}, sub);
                e.acc = edges;
                q.push_back(e);
                i++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        nchk++;
        if (cyc >= 50) begin
            nfail++;
            $display("FAIL dir_timeout: %0d results outstanding, required 0", q.size());
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        int          i, cyc, got;
        bit          stalled;
        logic [31:0] hold;
        i = 0; cyc = 0; got = 0; stalled = 0; hold = '0;
        q.delete(); stalls = 0; head_seen = 0;
        while ((i < 6 || q.size() > 0) && cyc < 60) begin
            in_valid  = (i < 6);
            a         = $urandom;
            b         = $urandom;
            sub       = 1'($urandom_range(0, 1));
            out_ready = !(cyc >= 3 && cyc < 6);
            #1;
            if (out_valid && !out_ready) begin
                nchk++;
                if (in_ready !== 1'b0) begin
                    nfail++;
                    $display("FAIL bp_in_ready: got %b required 0 while stalled", in_ready);
                end
            end
            if (stalled) begin
                nchk++;
                if (sum !== hold) begin
                    nfail++;
                    $display("FAIL bp_hold: sum got %h required %h", sum, hold);
                end
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    nchk++; nfail++;
                    $display("FAIL bp_spurious: out_valid=1 with nothing expected");
                end else begin
                    e = q[0];
                    if (!head_seen) begin
                        head_seen = 1;
                        nchk++;
                        if (edges !== e.acc + ST + stalls - e.stl) begin
                            nfail++;
                            $display("FAIL bp_latency: got %0d required %0d",
                                     edges - e.acc, ST + stalls - e.stl);
                        end
                    end
                    nchk++;
                    if (sum !== e.s[W-1:0]) begin
                        nfail++;
                        $display("FAIL bp_sum: got %h required %h", sum, e.s[W-1:0]);
                    end
                    if (out_ready) begin
                        void'(q.pop_front());
                        head_seen = 0;
                        got++;
                    end
                end
            end
            stalled = out_valid && !out_ready;
            hold    = sum;
            if (stalled) stalls++;
            if (in_valid && in_ready) begin
                e = model(W, {32'd0, a}, {32'd0, b}, sub);
                e.acc = edges;
                e.stl = stalls;
                q.push_back(e);
                i++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        nchk++;
        if (got !== 6) begin
            nfail++;
            $display("FAIL bp_count: got %0d results required 6", got);
        end
    endtask

    task automatic test_reset_flight();
        out_ready = 1'b1;
        in_valid  = 1'b1; a = 32'd1; b = 32'd2; sub = 1'b0;
        @(negedge clk);
        a = 32'd3; b = 32'd4;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        nchk++;
        if (out_valid !== 1'b1) begin
            nfail++;
            $display("FAIL rf_pre: out_valid got %b required 1", out_valid);
        end
        #1 rst_n = 1'b0;
        #1;
        nchk++;
        if (out_valid !== 1'b0 || sum !== '0) begin
            nfail++;
            $display("FAIL rf_async: out_valid=%b sum=%h required 0/0", out_valid, sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        nchk++;
        if (in_ready !== 1'b1) begin
            nfail++;
            $display("FAIL rf_ready: in_ready got %b required 1", in_ready);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            nchk++;
            if (out_valid !== 1'b0) begin
                nfail++;
                $display("FAIL rf_stale: out_valid=1 sum=%h %0d cycles after reset", sum, k + 1);
            end
        end
    endtask

    task automatic test_sweep();
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            int n, cyc, got, st;
            n = 0; cyc = 0; got = 0;
            st = (d == 0) ? 1 : (d == 1) ? 4 : 8;
            q.delete(); stalls = 0; head_seen = 0;
            while ((n < 1000 || q.size() > 0) && cyc < 20000) begin
                sw_iv[d]  = (n < 1000) && ($urandom_range(0, 3) != 0);
                sw_a[d]   = {$urandom, $urandom};
                sw_b[d]   = {$urandom, $urandom};
                sw_sub[d] = 1'($urandom_range(0, 1));
                sw_or[d]  = ($urandom_range(0, 3) != 0);
                #1;
                if (sw_ov[d]) begin
                    if (q.size() == 0) begin
                        nchk++; nfail++;
                        $display("FAIL sw%0d_spurious: out_valid=1 with nothing expected", st);
                    end else begin
                        e = q[0];
                        if (!head_seen) begin
                            head_seen = 1;
                            nchk++;
                            if (edges !== e.acc + st + stalls - e.stl) begin
                                nfail++;
                                $display("FAIL sw%0d_latency: got %0d required %0d",
                                         st, edges - e.acc, st + stalls - e.stl);
                            end
                        end
                        nchk++;
                        if (sw_sum[d] !== e.s) begin
                            nfail++;
                            $display("FAIL sw%0d_sum: got %h required %h", st, sw_sum[d], e.s);
                        end
`ifdef PIPE_ADD_FLAGS_EN
                        nchk++;
                        if ({sw_c[d], sw_o[d], sw_z[d]} !== {e.c, e.o, e.z}) begin
                            nfail++;
                            $display("FAIL sw%0d_flags: got %b required %b", st,
                                     {sw_c[d], sw_o[d], sw_z[d]}, {e.c, e.o, e.z});
                        end
`endif
                        if (sw_or[d]) begin
                            void'(q.pop_front());
                            head_seen = 0;
                            got++;
                        end
                    end
                end
                if (sw_ov[d] && !sw_or[d]) stalls++;
                if (sw_iv[d] && sw_ir[d]) begin
                    e = model(SWW, sw_a[d], sw_b[d], sw_sub[d]);
                    e.acc = edges;
                    e.stl = stalls;
                    q.push_back(e);
                    n++;
                end
                @(negedge clk);
                cyc++;
            end
            sw_iv[d] = 1'b0;
            nchk++;
            if (got !== 1000) begin
                nfail++;
                $display("FAIL sw%0d_count: got %0d results required 1000", st, got);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
        sw_iv = '0; sw_or = '0; sw_sub = '0; sw_a = '0; sw_b = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_flight();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
